sdr_cmd_receive: RTL and testbench

- Receive-side parser for the host command port (HPSDR protocol 2, UDP port 1024).
- Consumes payload bytes from the UDP receive path and decodes three commands: discovery request (0x02), erase request (0x04) and program block (0x05).
- Raises level handshakes to the reply transmitter and the flash (ASMI) interface, and streams program data into the flash write FIFO.
- Sits between the UDP/IP receive layer and the transmit/flash blocks, as the counterpart of the transmitter's discovery/erase/send_more reply logic.

---
 rtl/sdr_cmd_receive.sv | 146 ++++++++++++++
 tb/tb_sdr_cmd_receive.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_cmd_receive.sv
// sdr_cmd_receive: parses host command packets (discovery, erase, program block) from the UDP receive path
module sdr_cmd_receive #(
  parameter logic [15:0] CMD_PORT   = 16'd1024,
  parameter int          PROG_BLOCK = 256
) (
  input  logic        rx_clock,
  input  logic        reset_n,
  input  logic        udp_rx_active,
  input  logic        udp_rx_valid,
  input  logic [7:0]  udp_rx_data,
  input  logic [15:0] to_port,
  output logic        discovery,
  input  logic        discovery_ACK,
  output logic        erase_req,
  input  logic        erase_ACK,
  output logic        send_more,
  input  logic        send_more_ACK,
  output logic [31:0] sequence_number,
  output logic [31:0] total_blocks,
  output logic [7:0]  prog_wrdata,
  output logic        prog_wrreq,
  output logic        prog_abort,
  input  logic        prog_space_ok,
  output logic [7:0]  drop_count,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, HDR, PROG_HDR, PROG_DATA, DRAIN} state_t;
  localparam logic [9:0] LAST = 10'(PROG_BLOCK + 8);
  state_t      state_q, state_d;
  logic        act_q;
  logic [9:0]  byte_no_q, byte_no_d;
  logic [31:0] seq_tmp_q, seq_tmp_d, tot_tmp_q, tot_tmp_d, seq_q, seq_d, tot_q, tot_d;
  logic        disc_q, disc_d, erase_q, erase_d, sm_q, sm_d, wrreq_q, wrreq_d, abort_q, abort_d;
  logic [7:0]  wrdata_q, wrdata_d, drop_q, drop_d;
  logic        disc_set, erase_set, sm_set, drop;
  always_comb begin
    state_d   = state_q;
    byte_no_d = byte_no_q;
    seq_tmp_d = seq_tmp_q;
    tot_tmp_d = tot_tmp_q;
    seq_d     = seq_q;
    tot_d     = tot_q;
    wrdata_d  = wrdata_q;
    wrreq_d   = 1'b0;
    abort_d   = 1'b0;
    disc_set  = 1'b0;
    erase_set = 1'b0;
    sm_set    = 1'b0;
    drop      = 1'b0;
    case (state_q)
      IDLE: if (udp_rx_active) begin
        if (!act_q && to_port == CMD_PORT) begin
          state_d   = HDR;
          byte_no_d = {9'd0, udp_rx_valid};
          seq_tmp_d = udp_rx_valid ? {seq_tmp_q[23:0], udp_rx_data} : seq_tmp_q;
        end else state_d = DRAIN;
      end
      HDR: if (!udp_rx_active) begin
        drop    = 1'b1;
        state_d = IDLE;
      end else if (udp_rx_valid) begin
        byte_no_d = byte_no_q + 10'd1;
        if (byte_no_q < 10'd4) seq_tmp_d = {seq_tmp_q[23:0], udp_rx_data};
        else begin
          // Duplicates of a pending request are absorbed by the OR below, not counted as drops
          disc_set  = udp_rx_data == 8'h02;
          erase_set = udp_rx_data == 8'h04;
          state_d   = (udp_rx_data == 8'h05 && !sm_q && prog_space_ok) ? PROG_HDR : DRAIN;
          drop      = udp_rx_data != 8'h02 && udp_rx_data != 8'h04 &&
                      !(udp_rx_data == 8'h05 && !sm_q && prog_space_ok);
        end
      end
      PROG_HDR: if (!udp_rx_active) begin
        drop    = 1'b1;
        state_d = IDLE;
      end else if (udp_rx_valid) begin
        byte_no_d = byte_no_q + 10'd1;
        tot_tmp_d = {tot_tmp_q[23:0], udp_rx_data};
        state_d   = byte_no_q == 10'd8 ? PROG_DATA : PROG_HDR;
      end
      PROG_DATA: if (!udp_rx_active) begin
        drop    = 1'b1;
        abort_d = 1'b1;
        state_d = IDLE;
      end else if (udp_rx_valid) begin
        byte_no_d = byte_no_q + 10'd1;
        wrdata_d  = udp_rx_data;
        wrreq_d   = 1'b1;
        if (byte_no_q == LAST) begin
          seq_d   = seq_tmp_q;
          tot_d   = tot_tmp_q;
          sm_set  = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: state_d = udp_rx_active ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
    disc_d  = !discovery_ACK && (disc_q || disc_set);
    erase_d = !erase_ACK && (erase_q || erase_set);
    sm_d    = !send_more_ACK && (sm_q || sm_set);
    drop_d  = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge rx_clock) begin
    act_q <= udp_rx_active;
    if (!reset_n) begin
      state_q   <= IDLE;
      byte_no_q <= '0;
      seq_tmp_q <= '0;
      tot_tmp_q <= '0;
      seq_q     <= '0;
      tot_q     <= '0;
      disc_q    <= 1'b0;
      erase_q   <= 1'b0;
      sm_q      <= 1'b0;
      wrdata_q  <= '0;
      wrreq_q   <= 1'b0;
      abort_q   <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      byte_no_q <= byte_no_d;
      seq_tmp_q <= seq_tmp_d;
      tot_tmp_q <= tot_tmp_d;
      seq_q     <= seq_d;
      tot_q     <= tot_d;
      disc_q    <= disc_d;
      erase_q   <= erase_d;
      sm_q      <= sm_d;
      wrdata_q  <= wrdata_d;
      wrreq_q   <= wrreq_d;
      abort_q   <= abort_d;
      drop_q    <= drop_d;
    end
  end
  assign discovery       = disc_q;
  assign erase_req       = erase_q;
  assign send_more       = sm_q;
  assign sequence_number = seq_q;
  assign total_blocks    = tot_q;
  assign prog_wrdata     = wrdata_q;
  assign prog_wrreq      = wrreq_q;
  assign prog_abort      = abort_q;
  assign drop_count      = drop_q;
  assign busy            = state_q != IDLE;
endmodule

// File: tb/tb_sdr_cmd_receive.sv
// tb_sdr_cmd_receive: vector table, hand-written corner sequences and randomized packets against a packet-level model
module tb_sdr_cmd_receive;
  logic        rx_clock = 1'b0, reset_n = 1'b0;
  logic        udp_rx_active = 1'b0, udp_rx_valid = 1'b0;
  logic [7:0]  udp_rx_data = '0;
  logic [15:0] to_port = '0;
  logic        discovery_ACK = 1'b0, erase_ACK = 1'b0, send_more_ACK = 1'b0, prog_space_ok = 1'b1;
  logic        discovery, erase_req, send_more, prog_wrreq, prog_abort, busy;
  logic [31:0] sequence_number, total_blocks;
  logic [7:0]  prog_wrdata, drop_count;

  sdr_cmd_receive dut (
    .rx_clock(rx_clock), .reset_n(reset_n), .udp_rx_active(udp_rx_active), .udp_rx_valid(udp_rx_valid),
    .udp_rx_data(udp_rx_data), .to_port(to_port), .discovery(discovery), .discovery_ACK(discovery_ACK),
    .erase_req(erase_req), .erase_ACK(erase_ACK), .send_more(send_more), .send_more_ACK(send_more_ACK),
    .sequence_number(sequence_number), .total_blocks(total_blocks), .prog_wrdata(prog_wrdata),
    .prog_wrreq(prog_wrreq), .prog_abort(prog_abort), .prog_space_ok(prog_space_ok),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 rx_clock = ~rx_clock;

  typedef struct {
    logic [15:0] port;
    logic [7:0]  cmd;
    logic [31:0] seq, tot;
    int          n;
    logic        space;
    logic [2:0]  ack;
    logic        e_disc, e_erase, e_sm;
    logic [31:0] e_seq, e_tot;
    logic [7:0]  e_drop;
    int          e_nwr, e_abort;
  } vec_t;

  int checks = 0, passed = 0, aborts = 0;
  logic [7:0] pkt[$];
  logic [7:0] got_wr[$];
  logic [7:0] exp_wr[$];
  logic        m_disc, m_erase, m_sm;
  logic [31:0] m_seq, m_tot;
  logic [7:0]  m_drop;
  int          m_ab;

  always @(negedge rx_clock) begin
    if (prog_wrreq) got_wr.push_back(prog_wrdata);
    if (prog_abort) aborts++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge rx_clock);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    udp_rx_active = 1'b0;
    udp_rx_valid = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  function automatic void mk(input logic [7:0] cmd, input logic [31:0] seq, input logic [31:0] tot, input bit rnd);
    pkt.delete();
    for (int i = 3; i >= 0; i--) pkt.push_back(seq[8*i +: 8]);
    pkt.push_back(cmd);
    for (int i = 3; i >= 0; i--) pkt.push_back(tot[8*i +: 8]);
    for (int i = 0; i < 270; i++) pkt.push_back(rnd ? 8'($urandom) : 8'(i));
  endfunction

  task automatic send(input logic [15:0] port, input int n, input bit gaps);
    to_port = port;
    udp_rx_active = 1'b1;
    udp_rx_valid = 1'b0;
    tick;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        udp_rx_valid = 1'b0;
        tick;
      end
      udp_rx_valid = 1'b1;
      udp_rx_data = pkt[i];
      tick;
    end
    udp_rx_valid = 1'b0;
    udp_rx_active = 1'b0;
    tick;
    tick;
  endtask

  task automatic ack(input logic [2:0] a);
    if (a != 3'b000) begin
      {discovery_ACK, erase_ACK, send_more_ACK} = a;
      tick;
      {discovery_ACK, erase_ACK, send_more_ACK} = 3'b000;
    end
  endtask

  task automatic check_outputs(input string tag, input logic d, input logic e, input logic s,
                               input logic [31:0] sq, input logic [31:0] tt, input logic [7:0] dr, input int ab);
    chk({tag, "_discovery"}, 32'(discovery), 32'(d));
    chk({tag, "_erase"}, 32'(erase_req), 32'(e));
    chk({tag, "_send_more"}, 32'(send_more), 32'(s));
    chk({tag, "_seq"}, sequence_number, sq);
    chk({tag, "_total"}, total_blocks, tt);
    chk({tag, "_drop"}, 32'(drop_count), 32'(dr));
    chk({tag, "_aborts"}, 32'(aborts), 32'(ab));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  function automatic void drop_inc;
    if (m_drop != 8'hFF) m_drop++;
  endfunction

  vec_t tv[11];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{16'd1024, 8'h02, 32'd0, 32'd0, 60, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 8'd0, 0, 0};
    tv[1]  = '{16'd1024, 8'h02, 32'd0, 32'd0, 60, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 8'd0, 0, 0};
    tv[2]  = '{16'd1024, 8'h05, 32'd7, 32'd16, 265, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 32'd7, 32'd16, 8'd0, 256, 0};
    tv[3]  = '{16'd1024, 8'h05, 32'd8, 32'd1, 265, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 32'd7, 32'd16, 8'd1, 0, 0};
    tv[4]  = '{16'd1024, 8'h09, 32'd0, 32'd0, 20, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 32'd7, 32'd16, 8'd2, 0, 0};
    tv[5]  = '{16'd1025, 8'h04, 32'd0, 32'd0, 20, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'd7, 32'd16, 8'd2, 0, 0};
    tv[6]  = '{16'd1024, 8'h05, 32'd9, 32'd2, 109, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'd7, 32'd16, 8'd3, 100, 1};
    tv[7]  = '{16'd1024, 8'h04, 32'd0, 32'd0, 10, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 32'd7, 32'd16, 8'd3, 0, 0};
    tv[8]  = '{16'd1024, 8'h05, 32'd3, 32'd3, 265, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'd7, 32'd16, 8'd4, 0, 0};
    tv[9]  = '{16'd1024, 8'h05, 32'h12345678, 32'hCAFEBABE, 270, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0,
               32'h12345678, 32'hCAFEBABE, 8'd4, 256, 0};
    tv[10] = '{16'd1024, 8'h02, 32'd0, 32'd0, 3, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0,
               32'h12345678, 32'hCAFEBABE, 8'd5, 0, 0};

    do_reset;
    aborts = 0;
    check_outputs("reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 8'd0, 0);
    chk("reset_wrreq", 32'(prog_wrreq), 32'd0);
    chk("reset_wrdata", 32'(prog_wrdata), 32'd0);

    mk(8'h02, 32'd0, 32'd0, 1'b0);
    to_port = 16'd1024;
    udp_rx_active = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      udp_rx_valid = 1'b1;
      udp_rx_data = pkt[i];
      tick;
    end
    chk("disc_before_cmd", 32'(discovery), 32'd0);
    udp_rx_data = pkt[4];
    tick;
    chk("disc_latency", 32'(discovery), 32'd1);
    udp_rx_valid = 1'b0;
    udp_rx_active = 1'b0;
    tick;
    discovery_ACK = 1'b1;
    tick;
    chk("disc_ack_clear", 32'(discovery), 32'd0);
    send(16'd1024, 20, 1'b0);
    chk("disc_blocked_by_ack", 32'(discovery), 32'd0);
    chk("disc_dup_no_drop", 32'(drop_count), 32'd0);
    discovery_ACK = 1'b0;

    mk(8'h05, 32'd1, 32'd1, 1'b0);
    udp_rx_active = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) begin
      udp_rx_valid = 1'b1;
      udp_rx_data = pkt[i];
      tick;
    end
    chk("wr_latency_req", 32'(prog_wrreq), 32'd1);
    chk("wr_latency_data", 32'(prog_wrdata), 32'(pkt[9]));
    udp_rx_valid = 1'b0;
    tick;
    chk("wr_gap_idle", 32'(prog_wrreq), 32'd0);
    udp_rx_valid = 1'b1;
    udp_rx_data = pkt[10];
    tick;
    chk("wr_second_data", 32'(prog_wrdata), 32'(pkt[10]));
    udp_rx_valid = 1'b0;
    udp_rx_active = 1'b0;
    tick;
    chk("abort_pulse", 32'(prog_abort), 32'd1);
    tick;
    chk("abort_one_cycle", 32'(prog_abort), 32'd0);
    chk("abort_send_more", 32'(send_more), 32'd0);
    chk("abort_drop", 32'(drop_count), 32'd1);

    do_reset;
    for (int v = 0; v < 11; v++) begin
      logic bad;
      prog_space_ok = tv[v].space;
      got_wr.delete();
      aborts = 0;
      mk(tv[v].cmd, tv[v].seq, tv[v].tot, 1'b0);
      send(tv[v].port, tv[v].n, 1'b0);
      ack(tv[v].ack);
      check_outputs($sformatf("vec%0d", v), tv[v].e_disc, tv[v].e_erase, tv[v].e_sm,
                    tv[v].e_seq, tv[v].e_tot, tv[v].e_drop, tv[v].e_abort);
      chk($sformatf("vec%0d_nwr", v), 32'(got_wr.size()), 32'(tv[v].e_nwr));
      bad = 1'b0;
      foreach (got_wr[j]) if (got_wr[j] !== 8'(j)) bad = 1'b1;
      chk($sformatf("vec%0d_wrdata", v), 32'(bad), 32'd0);
    end
    prog_space_ok = 1'b1;

    mk(8'h02, 32'd0, 32'd0, 1'b0);
    to_port = 16'd1024;
    udp_rx_active = 1'b1;
    tick;
    for (int i = 0; i < 2; i++) begin
      udp_rx_valid = 1'b1;
      udp_rx_data = pkt[i];
      tick;
    end
    udp_rx_valid = 1'b0;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    aborts = 0;
    check_outputs("midrst", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 8'd0, 0);
    chk("midrst_wrreq", 32'(prog_wrreq), 32'd0);
    for (int i = 2; i < 20; i++) begin
      udp_rx_valid = 1'b1;
      udp_rx_data = pkt[i];
      tick;
    end
    chk("midrst_ignored", 32'(discovery), 32'd0);
    chk("midrst_drain_busy", 32'(busy), 32'd1);
    udp_rx_valid = 1'b0;
    udp_rx_active = 1'b0;
    tick;
    tick;
    send(16'd1024, 20, 1'b0);
    chk("midrst_next_disc", 32'(discovery), 32'd1);
    chk("midrst_next_drop", 32'(drop_count), 32'd0);

    do_reset;
    {m_disc, m_erase, m_sm} = 3'b000;
    m_seq = '0;
    m_tot = '0;
    m_drop = '0;
    for (int k = 0; k < 60; k++) begin
      logic [15:0] port;
      logic [7:0]  cmd;
      logic [2:0]  a;
      int r, full, n;
      logic bad;
      port = ($urandom_range(0, 7) == 0) ? 16'd1025 : 16'd1024;
      r = $urandom_range(0, 9);
      cmd = r < 3 ? 8'h02 : r < 5 ? 8'h04 : r < 8 ? 8'h05 : 8'($urandom_range(6, 255));
      full = cmd == 8'h05 ? 265 : 5 + $urandom_range(0, 20);
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, full - 1) : full + $urandom_range(0, 3);
      prog_space_ok = $urandom_range(0, 4) != 0;
      mk(cmd, $urandom, $urandom, 1'b1);
      exp_wr.delete();
      m_ab = 0;
      if (port == 16'd1024) begin
        if (n < 5) drop_inc();
        else if (pkt[4] == 8'h02) m_disc = 1'b1;
        else if (pkt[4] == 8'h04) m_erase = 1'b1;
        else if (pkt[4] == 8'h05) begin
          if (m_sm || !prog_space_ok || n < 9) drop_inc();
          else begin
            for (int j = 9; j < n && j < 265; j++) exp_wr.push_back(pkt[j]);
            if (n < 265) begin
              drop_inc();
              m_ab = 1;
            end else begin
              m_seq = {pkt[0], pkt[1], pkt[2], pkt[3]};
              m_tot = {pkt[5], pkt[6], pkt[7], pkt[8]};
              m_sm = 1'b1;
            end
          end
        end else drop_inc();
      end
      got_wr.delete();
      aborts = 0;
      send(port, n, 1'b1);
      a = 3'($urandom_range(0, 7));
      ack(a);
      if (a[2]) m_disc = 1'b0;
      if (a[1]) m_erase = 1'b0;
      if (a[0]) m_sm = 1'b0;
      check_outputs($sformatf("rnd%0d", k), m_disc, m_erase, m_sm, m_seq, m_tot, m_drop, m_ab);
      chk($sformatf("rnd%0d_nwr", k), 32'(got_wr.size()), 32'(exp_wr.size()));
      bad = got_wr.size() != exp_wr.size();
      foreach (got_wr[j]) if (j < exp_wr.size() && got_wr[j] !== exp_wr[j]) bad = 1'b1;
      chk($sformatf("rnd%0d_wrdata", k), 32'(bad), 32'd0);
    end

    prog_space_ok = 1'b1;
    mk(8'h09, 32'd0, 32'd0, 1'b0);
    for (int k = 0; k < 260; k++) begin
      send(16'd1024, 5, 1'b0);
      drop_inc();
    end
    chk("drop_sat_model", 32'(drop_count), 32'(m_drop));
    chk("drop_sat_ff", 32'(drop_count), 32'hFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
